// File: rtl/code_decoder_pkg.sv
// Shared types, default sizing and the one-hot helper for the code decoder.
package code_decoder_pkg;

  localparam int unsigned CODE_W_DEF = 3;
  localparam int unsigned OUT_W_DEF  = 1 << CODE_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Expand a binary index into its one-hot line.
  function automatic logic [OUT_W_DEF-1:0] onehot_of(input logic [CODE_W_DEF-1:0] code);
    logic [OUT_W_DEF-1:0] one;
    one = {{(OUT_W_DEF - 1){1'b0}}, 1'b1};
    return one << code;
  endfunction

endpackage

// File: rtl/code_decoder_if.sv
// Code-in / one-hot-out handshake bundle for the code decoder.
interface code_decoder_if
  import code_decoder_pkg::*;
#(
  parameter int unsigned CODE_W = CODE_W_DEF
);
  localparam int unsigned OUT_W = 1 << CODE_W;

  logic              in_valid;
  logic [CODE_W-1:0] in_code;
  logic              in_ready;
  logic [OUT_W-1:0]  out_onehot;
  logic              out_active;
  logic              done;

  modport master (
    output in_valid, in_code,
    input  in_ready, out_onehot, out_active, done
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, out_onehot, out_active, done
  );

endinterface

// File: rtl/code_decoder_hold_counter.sv
// Loadable down-counter with a zero flag, shared by the HOLD and GAP phases.
module hold_counter
  import code_decoder_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero_c,
  output logic         zero_next_c
);

  logic [W-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

  // Zero flag as it will read after the coming edge, for registered outputs.
  always_comb begin
    if (load) begin
      zero_next_c = (load_val == '0);
    end else if (dec) begin
      zero_next_c = (count <= W'(1));
    end else begin
      zero_next_c = (count == '0);
    end
  end

endmodule

// File: rtl/code_decoder.sv
// Sequential N-to-2**N decoder: accepted code drives a timed one-hot strobe.
module code_decoder
  import code_decoder_pkg::*;
#(
  parameter int unsigned CODE_W      = CODE_W_DEF,
  parameter int          HOLD_CYCLES = 4,
  parameter int          GAP_CYCLES  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  code_decoder_if.slave  bus
);

  localparam int unsigned OUT_W     = 1 << CODE_W;
  localparam int unsigned MAX_CYC   = unsigned'((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES);
  localparam int unsigned CNT_W     = $clog2(MAX_CYC + 1);
  localparam int unsigned HOLD_LOAD = unsigned'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam int unsigned GAP_LOAD  = unsigned'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Reject illegal phase lengths at elaboration.
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("code_decoder: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("code_decoder: GAP_CYCLES must be >= 0");
  end

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                cnt_load, cnt_dec;
  logic [CNT_W-1:0]    cnt_load_val;
  logic                cnt_zero_c, cnt_zero_next_c;
  logic [OUT_W-1:0]    onehot_c;

  logic                in_ready_q, in_ready_d;
  logic [OUT_W-1:0]    onehot_q, onehot_d;
  logic                active_q, active_d;
  logic                done_q, done_d;

  hold_counter #(.W(CNT_W)) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (cnt_load),
    .dec         (cnt_dec),
    .load_val    (cnt_load_val),
    .zero_c      (cnt_zero_c),
    .zero_next_c (cnt_zero_next_c)
  );

  // One-hot of the code that will be held after the coming edge.
  if (CODE_W == CODE_W_DEF) begin : g_pkg_onehot
    assign onehot_c = onehot_of(code_d);
  end else begin : g_shift_onehot
    assign onehot_c = OUT_W'(1) << code_d;
  end

  // State, latched code and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      code_q     <= '0;
      in_ready_q <= 1'b1;
      onehot_q   <= '0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      in_ready_q <= in_ready_d;
      onehot_q   <= onehot_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  // Next state, counter control and next output values.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    in_ready_d   = 1'b0;
    onehot_d     = '0;
    active_d     = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d      = HOLD;
          code_d       = bus.in_code;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(HOLD_LOAD);
        end
      end
      HOLD: begin
        if (cnt_zero_c) begin
          if (GAP_CYCLES > 0) begin
            state_d      = GAP;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(GAP_LOAD);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero_c) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    if (state_d == HOLD) begin
      onehot_d = onehot_c;
      active_d = 1'b1;
      done_d   = cnt_zero_next_c;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_onehot = onehot_q;
  assign bus.out_active = active_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_code_decoder.sv
// Bench for code_decoder: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0)
// against a timeline model of when each accepted code is visible.
module tb_code_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit         vld [2];
  logic [2:0] cd  [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  code_decoder_if #(.CODE_W(3)) if0 ();
  code_decoder_if #(.CODE_W(3)) if1 ();

  assign if0.in_valid = vld[0];
  assign if0.in_code  = cd[0];
  assign if1.in_valid = vld[1];
  assign if1.in_code  = cd[1];

  code_decoder #(.CODE_W(3), .HOLD_CYCLES(4), .GAP_CYCLES(1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  code_decoder #(.CODE_W(3), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  function automatic int hold_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // Timeline model: last accepted code and the edge that accepted it.
  bit have     [2];
  int acc_edge [2];
  int acc_code [2];
  int edge_n = 0;

  function automatic bit model_ready(input int i);
    return !have[i] || ((edge_n - acc_edge[i]) >= (hold_of(i) + gap_of(i)));
  endfunction

  // {in_ready, out_active, done, out_onehot} as they must read now.
  function automatic logic [10:0] expect_of(input int i);
    logic [10:0] e;
    int d;
    int h;
    e = {1'b1, 1'b0, 1'b0, 8'h00};
    h = hold_of(i);
    if (have[i]) begin
      d = edge_n - acc_edge[i];
      if (d < h) begin
        e = {1'b0, 1'b1, (d == h - 1), 8'(1 << acc_code[i])};
      end else if (d < h + gap_of(i)) begin
        e = {1'b0, 1'b0, 1'b0, 8'h00};
      end
    end
    return e;
  endfunction

  function automatic logic [10:0] act_of(input int i);
    if (i == 0) return {if0.in_ready, if0.out_active, if0.done, if0.out_onehot};
    return {if1.in_ready, if1.out_active, if1.done, if1.out_onehot};
  endfunction

  function automatic bit rdy(input int i);
    return (i == 0) ? if0.in_ready : if1.in_ready;
  endfunction

  // Priority encoder: index of the highest set bit, -1 when none.
  function automatic int prio_enc(input logic [7:0] v);
    int r;
    r = -1;
    for (int b = 0; b < 8; b++) begin
      if (v[b]) r = b;
    end
    return r;
  endfunction

  // Advance the model on each rising edge from the inputs seen there.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        have[i] <= 1'b0;
      end else if (model_ready(i) && vld[i]) begin
        have[i]     <= 1'b1;
        acc_edge[i] <= edge_n + 1;
        acc_code[i] <= int'(cd[i]);
      end
    end
    edge_n <= edge_n + 1;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [10:0] a;
        logic [10:0] e;
        a = act_of(i);
        e = expect_of(i);
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL model_dut%0d edge %0d: got ready=%b active=%b done=%b onehot=%b, want ready=%b active=%b done=%b onehot=%b",
                   i, edge_n, a[10], a[9], a[8], a[7:0], e[10], e[9], e[8], e[7:0]);
        end
        if (e[9]) begin
          checks++;
          if (prio_enc(a[7:0]) != acc_code[i]) begin
            errors++;
            $display("FAIL roundtrip_dut%0d edge %0d: encoder gives %0d, want %0d",
                     i, edge_n, prio_enc(a[7:0]), acc_code[i]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Present a code, wait (bounded) for it to be accepted; returns in the first hold cycle.
  task automatic send(input int i, input logic [2:0] c);
    int n;
    vld[i] = 1'b1;
    cd[i]  = c;
    n = 0;
    while (!rdy(i) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(rdy(i)), 32'd1);
    @(negedge clk);
    check("accept_seen", 32'(rdy(i)), 32'd0);
  endtask

  initial begin
    logic [2:0] c;
    vld[0] = 1'b1; cd[0] = 3'd3;
    vld[1] = 1'b1; cd[1] = 3'd7;
    rst_n  = 1'b0;

    // Reset with in_valid high: no accept, reset outputs.
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_valid_ready0", 32'(if0.in_ready), 32'd1);
    check("rst_valid_onehot0", 32'(if0.out_onehot), 32'h00);
    @(negedge clk);
    check("rst_valid_ready1", 32'(if1.in_ready), 32'd1);
    check("rst_valid_onehot1", 32'(if1.out_onehot), 32'h00);

    // Code 3 on HOLD=4/GAP=1.
    vld[1] = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    check("c3_ready_drop", 32'(if0.in_ready), 32'd0);
    check("c3_hold1", 32'(if0.out_onehot), 32'b0000_1000);
    vld[0] = 1'b0;
    cd[0]  = 3'($urandom);
    @(negedge clk);
    check("c3_hold2", 32'(if0.out_onehot), 32'b0000_1000);
    @(negedge clk);
    check("c3_hold3", 32'(if0.out_onehot), 32'b0000_1000);
    check("c3_no_early_done", 32'(if0.done), 32'd0);
    @(negedge clk);
    check("c3_hold4", 32'(if0.out_onehot), 32'b0000_1000);
    check("c3_done", 32'(if0.done), 32'd1);
    @(negedge clk);
    check("c3_gap_onehot", 32'(if0.out_onehot), 32'h00);
    check("c3_gap_ready", 32'(if0.in_ready), 32'd0);
    @(negedge clk);
    check("c3_ready_back", 32'(if0.in_ready), 32'd1);

    // Code 7 on HOLD=1/GAP=0.
    vld[1] = 1'b1;
    cd[1]  = 3'd7;
    @(negedge clk);
    check("c7_onehot", 32'(if1.out_onehot), 32'b1000_0000);
    check("c7_done", 32'(if1.done), 32'd1);
    vld[1] = 1'b0;
    @(negedge clk);
    check("c7_ready_next", 32'(if1.in_ready), 32'd1);
    check("c7_onehot_off", 32'(if1.out_onehot), 32'h00);

    // Back-to-back sweep of all codes on both instances.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) begin
        c = 3'(k);
        send(i, c);
        check("sweep_onehot", 32'(act_of(i)), 32'({3'b010, 8'h00} | (11'(1) << k) | (hold_of(i) == 1 ? 11'h100 : 11'h000)));
        check("sweep_encode", 32'(prio_enc(act_of(i) & 11'h0ff)), 32'(k));
      end
      vld[i] = 1'b0;
    end
    repeat (8) @(negedge clk);

    // Reset during the 2nd hold cycle of code 5.
    send(0, 3'd5);
    vld[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_onehot", 32'(if0.out_onehot), 32'h00);
    check("abort_ready", 32'(if0.in_ready), 32'd1);
    check("abort_active", 32'(if0.out_active), 32'd0);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      check("abort_no_done", 32'(if0.done), 32'd0);
      @(negedge clk);
    end

    // Inputs toggling during HOLD/GAP are ignored.
    send(0, 3'd2);
    for (int j = 1; j <= 4; j++) begin
      vld[0] = 1'($urandom_range(0, 1));
      cd[0]  = 3'($urandom);
      @(negedge clk);
      if (j <= 3) check("ignore_hold", 32'(if0.out_onehot), 32'b0000_0100);
      else        check("ignore_gap", 32'(if0.out_onehot), 32'h00);
    end
    vld[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Reset and valid in the same cycle while idle.
    rst_n  = 1'b0;
    vld[0] = 1'b1;
    cd[0]  = 3'd6;
    @(negedge clk);
    vld[0] = 1'b0;
    rst_n  = 1'b1;
    check("rst_accept_ready", 32'(if0.in_ready), 32'd1);
    @(negedge clk);
    check("rst_accept_none", 32'(if0.out_onehot), 32'h00);
    check("rst_accept_idle", 32'(if0.in_ready), 32'd1);

    // Randomized traffic with occasional resets.
    repeat (600) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 3) != 0);
        cd[i]  = 3'($urandom);
      end
      rst_n = ($urandom_range(0, 63) != 0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
